// File: rtl/io_pkg.sv
// Shared constants and helpers for the key/switch input device: register map,
// control-register bit positions and the per-device flag update rule.
package io_pkg;

    localparam int DBITS = 32;

    localparam logic [31:0] KDATA_ADDR = 32'hFFFF_F080;
    localparam logic [31:0] KCTRL_ADDR = 32'hFFFF_F084;
    localparam logic [31:0] SDATA_ADDR = 32'hFFFF_F090;
    localparam logic [31:0] SCTRL_ADDR = 32'hFFFF_F094;

    localparam int RDY_BIT = 0;
    localparam int OVR_BIT = 2;
    localparam int IE_BIT  = 8;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_KDATA,
        REG_KCTRL,
        REG_SDATA,
        REG_SCTRL
    } reg_sel_e;

    typedef struct packed {
        logic rdy;
        logic ovr;
        logic ie;
    } dev_flags_t;

    // A commit in the same cycle as a data read keeps ready set; an
    // overrun-clear write beats a simultaneous overrun set.
    function automatic dev_flags_t next_flags(input dev_flags_t cur,
                                              input logic       chg,
                                              input logic       data_read,
                                              input logic       ctrl_write,
                                              input logic       wr_ovr,
                                              input logic       wr_ie);
        dev_flags_t nxt;
        nxt = cur;
        if (chg) begin
            nxt.rdy = 1'b1;
            if (cur.rdy && !data_read) nxt.ovr = 1'b1;
        end else if (data_read) begin
            nxt.rdy = 1'b0;
        end
        if (ctrl_write) begin
            nxt.ie = wr_ie;
            if (!wr_ovr) nxt.ovr = 1'b0;
        end
        return nxt;
    endfunction

    function automatic logic [31:0] ctrl_word(input dev_flags_t f);
        logic [31:0] w;
        w          = '0;
        w[RDY_BIT] = f.rdy;
        w[OVR_BIT] = f.ovr;
        w[IE_BIT]  = f.ie;
        return w;
    endfunction

endpackage

// File: rtl/key_sw_io_if.sv
// MEM-stage data-bus port of the key/switch device; the CPU side is the
// master, the device is the slave.
interface key_sw_io_if #(
    parameter int DBITS = io_pkg::DBITS
);
    logic [DBITS-1:0] addr;
    logic             rd_en;
    logic             wr_en;
    logic [DBITS-1:0] wrdata;
    logic [DBITS-1:0] rddata;
    logic             sel;
    logic             intr;

    modport master (
        output addr, rd_en, wr_en, wrdata,
        input  rddata, sel, intr
    );

    modport slave (
        input  addr, rd_en, wr_en, wrdata,
        output rddata, sel, intr
    );
endinterface

// File: rtl/io_debounce.sv
// Two-flop synchronizer followed by a stable-count debouncer; raises a
// one-cycle chg in the cycle the debounced data register takes a new value.
module io_debounce #(
    parameter int WIDTH           = 1,
    parameter int DEBOUNCE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] data,
    output logic             chg
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q1;
    logic [WIDTH-1:0] sync_q2;
    logic [WIDTH-1:0] cand;
    logic [CW-1:0]    cnt;

    // chg is combinational so ready can set on the same edge data commits.
    assign chg = (sync_q2 == cand) && (cnt == TERM) && (cand != data);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
            cand    <= '0;
            cnt     <= '0;
            data    <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of
            // the one before it; blocking would collapse the synchronizer.
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
            if (sync_q2 != cand) begin
                cand <= sync_q2;
                cnt  <= '0;
            end else if (cnt < TERM) begin
                cnt <= cnt + CW'(1);
            end else if (chg) begin
                data <= cand;
            end
        end
    end

endmodule

// File: rtl/key_sw_io.sv
// Memory-mapped key/switch input device: debounced data registers with
// ready/overrun/interrupt-enable flags per device on the MEM-stage bus.
module key_sw_io #(
    parameter int DBITS           = io_pkg::DBITS,
    parameter int KEYBITS         = 4,
    parameter int SWBITS          = 10,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [KEYBITS-1:0] KEY,
    input  logic [SWBITS-1:0]  SW,
    key_sw_io_if.slave         bus
);
    import io_pkg::*;

    logic [KEYBITS-1:0] kdata;
    logic [SWBITS-1:0]  sdata;
    logic               kchg;
    logic               schg;
    dev_flags_t         kflags;
    dev_flags_t         sflags;
    reg_sel_e           reg_sel;
    logic               unused_wrdata;

    io_debounce #(.WIDTH(KEYBITS), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_db (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (~KEY),
        .data    (kdata),
        .chg     (kchg)
    );

    io_debounce #(.WIDTH(SWBITS), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw_db (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (SW),
        .data    (sdata),
        .chg     (schg)
    );

    always_comb begin
        reg_sel = REG_NONE;
        if      (bus.addr == DBITS'(KDATA_ADDR)) reg_sel = REG_KDATA;
        else if (bus.addr == DBITS'(KCTRL_ADDR)) reg_sel = REG_KCTRL;
        else if (bus.addr == DBITS'(SDATA_ADDR)) reg_sel = REG_SDATA;
        else if (bus.addr == DBITS'(SCTRL_ADDR)) reg_sel = REG_SCTRL;
    end

    assign bus.sel = (reg_sel != REG_NONE);

    always_comb begin
        // NOTE: default assigned first so every path drives rddata and no
        // latch is inferred.
        bus.rddata = '0;
        if (bus.rd_en) begin
            case (reg_sel)
                REG_KDATA: bus.rddata = DBITS'(kdata);
                REG_KCTRL: bus.rddata = DBITS'(ctrl_word(kflags));
                REG_SDATA: bus.rddata = DBITS'(sdata);
                REG_SCTRL: bus.rddata = DBITS'(ctrl_word(sflags));
                default:   bus.rddata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            kflags   <= '0;
            sflags   <= '0;
            bus.intr <= 1'b0;
        end else begin
            kflags <= next_flags(kflags, kchg,
                                 bus.rd_en && (reg_sel == REG_KDATA),
                                 bus.wr_en && (reg_sel == REG_KCTRL),
                                 bus.wrdata[OVR_BIT], bus.wrdata[IE_BIT]);
            sflags <= next_flags(sflags, schg,
                                 bus.rd_en && (reg_sel == REG_SDATA),
                                 bus.wr_en && (reg_sel == REG_SCTRL),
                                 bus.wrdata[OVR_BIT], bus.wrdata[IE_BIT]);
            bus.intr <= (kflags.rdy & kflags.ie) | (sflags.rdy & sflags.ie);
        end
    end

    // Only the overrun and IE bits of a store carry meaning.
    assign unused_wrdata = ^{bus.wrdata[DBITS-1:IE_BIT+1],
                             bus.wrdata[IE_BIT-1:OVR_BIT+1],
                             bus.wrdata[OVR_BIT-1:0]};

endmodule
